// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC arbiter: the end-to-end latency, a
// one-hot-to-index helper and a macro that slices a packed per-requester bus.
`ifndef CORDIC_ARB_SLICE
`define CORDIC_ARB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package cordic_arb_pkg;

  localparam int unsigned STAGES_DEF  = 16;
  localparam int unsigned LATENCY_DEF = STAGES_DEF + 2;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_arbiter.sv
// Round-robin grant: the first valid index strictly after last_grant wins.
// Grant is combinational; last_grant moves only when a transfer is taken.
module rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            en,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          found;
  int            scan_idx;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(last_grant_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (en && !found && valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        found           = 1'b1;
      end
    end
    last_grant_d = last_grant_q;
    if (advance) last_grant_d = IW'(onehot_to_idx(8'(grant)));
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= IW'(NREQ - 1);
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one fixed-latency CORDIC among NREQ requesters: launches one granted
// request per cycle and steers each result back using a latency-matched tag pipe.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ZWIDTH = 24,
  parameter int STAGES = 16,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WIDTH-1:0]  req_xi,
  input  logic [NREQ*WIDTH-1:0]  req_yi,
  input  logic [NREQ*ZWIDTH-1:0] req_zi,
  output logic [WIDTH-1:0]       cordic_xi,
  output logic [WIDTH-1:0]       cordic_yi,
  output logic [ZWIDTH-1:0]      cordic_zi,
  output logic                   cordic_stb_in,
  input  logic [WIDTH-1:0]       cordic_xo,
  input  logic [WIDTH-1:0]       cordic_yo,
  input  logic [ZWIDTH-1:0]      cordic_zo,
  input  logic                   cordic_stb_out,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_xo,
  output logic [WIDTH-1:0]       rsp_yo,
  output logic [ZWIDTH-1:0]      rsp_zo,
  output logic                   sync_err
);

  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [2:0]        sel_idx;
  logic [NREQ-1:0]   tail;
  logic              tail_hit;

  logic [WIDTH-1:0]  xi_q, xi_d, yi_q, yi_d;
  logic [ZWIDTH-1:0] zi_q, zi_d;
  logic              stb_in_q, stb_in_d;
  logic [NREQ-1:0]   launch_tag_q, launch_tag_d;
  logic [NREQ-1:0]   tag_q [STAGES];
  logic [NREQ-1:0]   tag_d [STAGES];
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_xo_q, rsp_xo_d, rsp_yo_q, rsp_yo_d;
  logic [ZWIDTH-1:0] rsp_zo_q, rsp_zo_d;
  logic              sync_err_q, sync_err_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .en      (en),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer     = |grant;
  assign sel_idx  = onehot_to_idx(8'(grant));
  assign tail     = tag_q[STAGES-1];
  assign tail_hit = |tail;

  always_comb begin
    xi_d         = xi_q;
    yi_d         = yi_q;
    zi_d         = zi_q;
    stb_in_d     = xfer;
    launch_tag_d = grant;
    if (xfer) begin
      xi_d = `CORDIC_ARB_SLICE(req_xi, sel_idx, WIDTH);
      yi_d = `CORDIC_ARB_SLICE(req_yi, sel_idx, WIDTH);
      zi_d = `CORDIC_ARB_SLICE(req_zi, sel_idx, ZWIDTH);
    end
    // The tag enters the pipe while its operands are at the CORDIC input,
    // so the tail lines up with cordic_stb_out.
    tag_d[0] = launch_tag_q;
    for (int i = 1; i < STAGES; i++) tag_d[i] = tag_q[i-1];

    rsp_valid_d = '0;
    rsp_xo_d    = rsp_xo_q;
    rsp_yo_d    = rsp_yo_q;
    rsp_zo_d    = rsp_zo_q;
    if (tail_hit && cordic_stb_out) begin
      rsp_valid_d = tail;
      rsp_xo_d    = cordic_xo;
      rsp_yo_d    = cordic_yo;
      rsp_zo_d    = cordic_zo;
    end
    sync_err_d = sync_err_q | (tail_hit ^ cordic_stb_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xi_q         <= '0;
      yi_q         <= '0;
      zi_q         <= '0;
      stb_in_q     <= 1'b0;
      launch_tag_q <= '0;
      for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
      rsp_valid_q  <= '0;
      rsp_xo_q     <= '0;
      rsp_yo_q     <= '0;
      rsp_zo_q     <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      xi_q         <= xi_d;
      yi_q         <= yi_d;
      zi_q         <= zi_d;
      stb_in_q     <= stb_in_d;
      launch_tag_q <= launch_tag_d;
      for (int i = 0; i < STAGES; i++) tag_q[i] <= tag_d[i];
      rsp_valid_q  <= rsp_valid_d;
      rsp_xo_q     <= rsp_xo_d;
      rsp_yo_q     <= rsp_yo_d;
      rsp_zo_q     <= rsp_zo_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign req_ready     = grant;
  assign cordic_xi     = xi_q;
  assign cordic_yi     = yi_q;
  assign cordic_zi     = zi_q;
  assign cordic_stb_in = stb_in_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_xo        = rsp_xo_q;
  assign rsp_yo        = rsp_yo_q;
  assign rsp_zo        = rsp_zo_q;
  assign sync_err      = sync_err_q;

endmodule
